input_vc_buffer: RTL and testbench
==================================

Name: input_vc_buffer

Overview:
- Per-virtual-channel flit FIFO and VC state machine inside the router input port; sits directly upstream of the route-computation unit.
- Stores incoming flits and, on a head flit at the FIFO head, presents its destination coordinates to the route-computation unit.
- Latches the returned output port and requests VC allocation, then switch allocation.
- Pops granted flits towards the crossbar and returns one credit upstream per popped flit.

Parameters:
- BUFFER_SIZE, 8, FIFO depth in flits; must be a power of 2, minimum 2.
- FLIT_W, 32, flit width in bits.
- DEST_ADDR_SIZE_X, 4, width of the X destination field.
- DEST_ADDR_SIZE_Y, 4, width of the Y destination field.
- VC_ID_W, 2, width of the downstream VC identifier.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flit_i  in  FLIT_W  incoming flit.
- valid_i  in  1  flit_i valid this cycle.
- x_dest_o  out  DEST_ADDR_SIZE_X  head-flit X destination to the route-computation unit.
- y_dest_o  out  DEST_ADDR_SIZE_Y  head-flit Y destination to the route-computation unit.
- out_port_i  in  port_t  computed output port, combinational return from the route-computation unit.
- va_request_o  out  1  VC allocation request.
- out_port_o  out  port_t  latched output port for the current packet.
- va_grant_i  in  1  VC allocation granted.
- vc_id_i  in  VC_ID_W  downstream VC assigned with the grant.
- vc_id_o  out  VC_ID_W  latched downstream VC.
- sa_request_o  out  1  switch allocation request.
- sa_grant_i  in  1  switch allocation granted; pop one flit.
- flit_o  out  FLIT_W  popped flit, registered.
- flit_valid_o  out  1  flit_o valid.
- credit_o  out  1  one-cycle pulse per popped flit.
- full_o  out  1  FIFO full.
- empty_o  out  1  FIFO empty.
- error_o  out  1  sticky protocol error.

Behaviour:
- Flit format:
  - Type field is flit[FLIT_W-1:FLIT_W-2]: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
  - Head flits carry X destination at the next DEST_ADDR_SIZE_X bits below the type field, followed by Y destination.
- FIFO:
  - Read/write pointers are log2(BUFFER_SIZE) bits and wrap naturally.
  - Occupancy counter is log2(BUFFER_SIZE)+1 bits.
  - Push when valid_i & (~full_o | pop this cycle).
  - Pop when sa_grant_i & state==ACTIVE & ~empty_o.
  - Push and pop in the same cycle leave occupancy unchanged, including at full.
  - valid_i while full with no pop: flit dropped, error_o set.
- x_dest_o/y_dest_o are combinational from the FIFO head flit, in every state.
- States:
  - IDLE:
    - If ~empty_o and head type is HEAD or HEADTAIL: latch out_port_i into out_port_o, go to WAIT_VA.
    - If the head type is BODY or TAIL: set error_o, stay in IDLE, do not pop.
  - WAIT_VA:
    - va_request_o=1.
    - On va_grant_i: latch vc_id_i into vc_id_o, go to ACTIVE.
  - ACTIVE:
    - sa_request_o = ~empty_o.
    - On pop: flit_o <= head flit, flit_valid_o=1 and credit_o=1 in the next cycle (one-cycle latency).
    - If the popped flit is TAIL or HEADTAIL, go to IDLE. A following head flit is routed starting that IDLE cycle.
- va_request_o and sa_request_o are 0 outside their states.
- sa_grant_i outside ACTIVE is ignored, with no pop.
- va_grant_i outside WAIT_VA is ignored.
- Reset values:
  - State IDLE; pointers and count 0.
  - empty_o=1, full_o=0.
  - flit_o=0, flit_valid_o=0, credit_o=0.
  - va_request_o=0, sa_request_o=0.
  - out_port_o=LOCAL, vc_id_o=0, error_o=0.
- Reset mid-packet discards all buffered flits and returns to IDLE immediately, asynchronously.
- error_o clears only on reset.

Test Plan:
- Reset, then idle 5 cycles -> empty_o=1, all requests 0, out_port_o=LOCAL, error_o=0.
- Push HEAD(dest 3,1), BODY, TAIL; out_port_i=EAST; va_grant_i with vc_id_i=2 one cycle after the request; sa_grant_i held high -> out_port_o=EAST, vc_id_o=2, three flits on flit_o in order with 3 credit_o pulses, then state IDLE.
- Single HEADTAIL flit -> one pop, returns to IDLE; a second HEADTAIL already queued raises va_request_o on the following cycle.
- Push 8 flits with no grants -> full_o=1; a 9th valid_i -> dropped, error_o=1. Repeat after reset with push and pop in the same cycle at full -> no drop, count stays 8.
- BODY flit arriving in IDLE -> error_o=1, no pop, no va_request_o.
- Assert rst after 2 of 3 flits have been popped -> empty_o=1, state IDLE, no further flit_valid_o.

Source files
------------

// File: rtl/input_vc_buffer.sv
// ============================================================================
// Module   : input_vc_buffer
// Purpose  : Per-VC input flit FIFO with route / VC-alloc / switch-alloc
//            state machine, registered flit output and credit return.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_vc_buffer_pkg;
  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_t;
endpackage

module input_vc_buffer
  import input_vc_buffer_pkg::*;
#(
  parameter int BUFFER_SIZE      = 8,
  parameter int FLIT_W           = 32,
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4,
  parameter int VC_ID_W          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_W-1:0]           flit_i,
  input  logic                        valid_i,
  output logic [DEST_ADDR_SIZE_X-1:0] x_dest_o,
  output logic [DEST_ADDR_SIZE_Y-1:0] y_dest_o,
  input  port_t                       out_port_i,
  output logic                        va_request_o,
  output port_t                       out_port_o,
  input  logic                        va_grant_i,
  input  logic [VC_ID_W-1:0]          vc_id_i,
  output logic [VC_ID_W-1:0]          vc_id_o,
  output logic                        sa_request_o,
  input  logic                        sa_grant_i,
  output logic [FLIT_W-1:0]           flit_o,
  output logic                        flit_valid_o,
  output logic                        credit_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        error_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(BUFFER_SIZE);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [1:0] TYPE_HEAD     = 2'b00;
  localparam logic [1:0] TYPE_TAIL     = 2'b10;
  localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VA = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;

  logic [FLIT_W-1:0]  mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic [1:0]         state_q, state_d;
  logic               error_q, error_d;
  port_t              out_port_q;
  logic [VC_ID_W-1:0] vc_id_q;
  logic [FLIT_W-1:0]  flit_q;
  logic               flit_valid_q;
  logic               credit_q;

  logic [FLIT_W-1:0]  head;
  logic [1:0]         head_type;
  logic               head_starts, head_ends;
  logic               pop, push, drop, route, bad_head;

  assign head        = mem_q[rd_ptr_q];
  assign head_type   = head[FLIT_W-1:FLIT_W-2];
  assign head_starts = (head_type == TYPE_HEAD) || (head_type == TYPE_HEADTAIL);
  assign head_ends   = (head_type == TYPE_TAIL) || (head_type == TYPE_HEADTAIL);

  assign x_dest_o = head[FLIT_W-3 -: DEST_ADDR_SIZE_X];
  assign y_dest_o = head[FLIT_W-3-DEST_ADDR_SIZE_X -: DEST_ADDR_SIZE_Y];

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop      = sa_grant_i && (state_q == S_ACTIVE) && !empty_o;
  assign push     = valid_i && (!full_o || pop);
  assign drop     = valid_i && full_o && !pop;
  assign route    = (state_q == S_IDLE) && !empty_o && head_starts;
  assign bad_head = (state_q == S_IDLE) && !empty_o && !head_starts;
  assign error_d  = error_q || drop || bad_head;

  assign out_port_o   = out_port_q;
  assign vc_id_o      = vc_id_q;
  assign flit_o       = flit_q;
  assign flit_valid_o = flit_valid_q;
  assign credit_o     = credit_q;
  assign error_o      = error_q;

  // Occupancy next value; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Flit storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= flit_i;
  end

  // FIFO pointers, occupancy and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: route a head, wait for a VC, then stream until the tail.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (route) state_d = S_WAIT_VA;
      S_WAIT_VA: if (va_grant_i) state_d = S_ACTIVE;
      S_ACTIVE:  if (pop && head_ends) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Allocation requests decoded from the current state.
  always_comb begin
    va_request_o = 1'b0;
    sa_request_o = 1'b0;
    case (state_q)
      S_WAIT_VA: va_request_o = 1'b1;
      S_ACTIVE:  sa_request_o = !empty_o;
      default: begin
        va_request_o = 1'b0;
        sa_request_o = 1'b0;
      end
    endcase
  end

  // Per-packet latches and the registered crossbar output with its credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port_q   <= LOCAL;
      vc_id_q      <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      credit_q     <= 1'b0;
    end else begin
      if (route) out_port_q <= out_port_i;
      if ((state_q == S_WAIT_VA) && va_grant_i) vc_id_q <= vc_id_i;
      if (pop) flit_q <= head;
      flit_valid_q <= pop;
      credit_q     <= pop;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_input_vc_buffer.sv
// ============================================================================
// Module   : tb_input_vc_buffer
// Purpose  : Self-checking bench for input_vc_buffer: directed table,
//            corner-case sequences and randomized packets against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_vc_buffer;
  import input_vc_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic        clk, rst;
  logic [31:0] flit_i;
  logic        valid_i;
  logic [3:0]  x_dest_o, y_dest_o;
  port_t       out_port_i, out_port_o;
  logic        va_request_o, va_grant_i;
  logic [1:0]  vc_id_i, vc_id_o;
  logic        sa_request_o, sa_grant_i;
  logic [31:0] flit_o;
  logic        flit_valid_o, credit_o, full_o, empty_o, error_o;

  input_vc_buffer #(
    .BUFFER_SIZE(DEPTH), .FLIT_W(32), .DEST_ADDR_SIZE_X(4),
    .DEST_ADDR_SIZE_Y(4), .VC_ID_W(2)
  ) dut (
    .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i),
    .x_dest_o(x_dest_o), .y_dest_o(y_dest_o), .out_port_i(out_port_i),
    .va_request_o(va_request_o), .out_port_o(out_port_o),
    .va_grant_i(va_grant_i), .vc_id_i(vc_id_i), .vc_id_o(vc_id_o),
    .sa_request_o(sa_request_o), .sa_grant_i(sa_grant_i), .flit_o(flit_o),
    .flit_valid_o(flit_valid_o), .credit_o(credit_o), .full_o(full_o),
    .empty_o(empty_o), .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: packet queue plus phase -------------
  // phase 0 = waiting for a head, 1 = waiting for VC, 2 = sending packet
  logic [31:0] mq[$];
  int          mphase;
  logic        m_fv, m_cr, m_err;
  logic [31:0] m_fo;
  port_t       m_port;
  logic [1:0]  m_vc;

  function automatic void model_reset();
    mq.delete();
    mphase = 0; m_fv = 0; m_cr = 0; m_err = 0; m_fo = '0; m_port = LOCAL; m_vc = '0;
  endfunction

  task automatic compare_model();
    chk("empty", empty_o, mq.size() == 0);
    chk("full", full_o, mq.size() == DEPTH);
    chk("va_req", va_request_o, mphase == 1);
    chk("sa_req", sa_request_o, (mphase == 2) && (mq.size() > 0));
    chk("flit_valid", flit_valid_o, m_fv);
    chk("credit", credit_o, m_cr);
    chk("flit_o", flit_o, m_fo);
    chk("error", error_o, m_err);
    chk("out_port", 64'(out_port_o), 64'(m_port));
    chk("vc_id", vc_id_o, m_vc);
    if (mq.size() > 0) begin
      chk("x_dest", x_dest_o, mq[0][29:26]);
      chk("y_dest", y_dest_o, mq[0][25:22]);
    end
  endtask

  function automatic void model_edge();
    logic [31:0] hd;
    logic [1:0]  ty;
    bit          pop, push;
    int          n;
    n    = mq.size();
    hd   = (n > 0) ? mq[0] : 32'h0;
    ty   = hd[31:30];
    pop  = sa_grant_i && (mphase == 2) && (n > 0);
    push = valid_i && ((n < DEPTH) || pop);
    if (valid_i && (n == DEPTH) && !pop) m_err = 1;
    case (mphase)
      0: if (n > 0) begin
           if (ty == 2'b00 || ty == 2'b11) begin m_port = out_port_i; mphase = 1; end
           else m_err = 1;
         end
      1: if (va_grant_i) begin m_vc = vc_id_i; mphase = 2; end
      default: if (pop && (ty == 2'b10 || ty == 2'b11)) mphase = 0;
    endcase
    m_fv = pop;
    m_cr = pop;
    if (pop) begin m_fo = hd; void'(mq.pop_front()); end
    if (push) mq.push_back(flit_i);
  endfunction

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    compare_model();
    advance();
  endtask

  task automatic drive(input logic v, input logic [31:0] f, input port_t p,
                       input logic vag, input logic [1:0] vc, input logic sag);
    valid_i = v; flit_i = f; out_port_i = p; va_grant_i = vag; vc_id_i = vc; sa_grant_i = sag;
  endtask

  task automatic do_reset();
    drive(0, 32'h0, LOCAL, 0, 2'd0, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed table ---------------------------------------
  typedef struct {
    logic        v;
    logic [31:0] f;
    port_t       p;
    logic        vag;
    logic [1:0]  vc;
    logic        sag;
    logic        e_va, e_sa, e_fv, e_cr, e_emp, e_full, e_err;
    logic [31:0] e_fo;
    port_t       e_port;
    logic [1:0]  e_vc;
  } vec_t;

  localparam logic [31:0] FH = {2'b00, 4'd3, 4'd1, 22'h0000AA};
  localparam logic [31:0] FB = {2'b01, 30'h1};
  localparam logic [31:0] FT = {2'b10, 30'h2};

  vec_t tbl[9];

  function automatic logic [31:0] mkflit(input logic [1:0] ty);
    mkflit = {ty, 30'($urandom)};
  endfunction

  int pkt_left = 0;

  initial begin
    rst = 1'b0;
    drive(0, 32'h0, LOCAL, 0, 2'd0, 0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state then idle.
    for (int i = 0; i < 5; i++) step();
    chk("rst_out_port", 64'(out_port_o), 64'(LOCAL));
    chk("rst_empty", empty_o, 1'b1);

    // HEAD/BODY/TAIL packet to EAST on VC 2, sa_grant held high.
    //           v  flit  port  vag vc sag | va sa fv cr emp full err fo  port  vc
    tbl[0] = '{1, FH,   EAST, 0, 0, 1,   0, 0, 0, 0, 1,  0,   0,  0,  LOCAL, 0};
    tbl[1] = '{1, FB,   EAST, 0, 0, 1,   0, 0, 0, 0, 0,  0,   0,  0,  LOCAL, 0};
    tbl[2] = '{1, FT,   EAST, 0, 0, 1,   1, 0, 0, 0, 0,  0,   0,  0,  EAST,  0};
    tbl[3] = '{0, 0,    EAST, 1, 2, 1,   1, 0, 0, 0, 0,  0,   0,  0,  EAST,  0};
    tbl[4] = '{0, 0,    EAST, 0, 0, 1,   0, 1, 0, 0, 0,  0,   0,  0,  EAST,  2};
    tbl[5] = '{0, 0,    EAST, 0, 0, 1,   0, 1, 1, 1, 0,  0,   0,  FH, EAST,  2};
    tbl[6] = '{0, 0,    EAST, 0, 0, 1,   0, 1, 1, 1, 0,  0,   0,  FB, EAST,  2};
    tbl[7] = '{0, 0,    EAST, 0, 0, 1,   0, 0, 1, 1, 1,  0,   0,  FT, EAST,  2};
    tbl[8] = '{0, 0,    EAST, 0, 0, 1,   0, 0, 0, 0, 1,  0,   0,  FT, EAST,  2};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].p, tbl[i].vag, tbl[i].vc, tbl[i].sag);
      #1;
      chk($sformatf("t%0d_va", i), va_request_o, tbl[i].e_va);
      chk($sformatf("t%0d_sa", i), sa_request_o, tbl[i].e_sa);
      chk($sformatf("t%0d_fv", i), flit_valid_o, tbl[i].e_fv);
      chk($sformatf("t%0d_cr", i), credit_o, tbl[i].e_cr);
      chk($sformatf("t%0d_empty", i), empty_o, tbl[i].e_emp);
      chk($sformatf("t%0d_full", i), full_o, tbl[i].e_full);
      chk($sformatf("t%0d_err", i), error_o, tbl[i].e_err);
      chk($sformatf("t%0d_fo", i), flit_o, tbl[i].e_fo);
      chk($sformatf("t%0d_port", i), 64'(out_port_o), 64'(tbl[i].e_port));
      chk($sformatf("t%0d_vc", i), vc_id_o, tbl[i].e_vc);
      compare_model();
      advance();
    end

    // Back-to-back HEADTAIL flits: second one routed in the IDLE cycle after the first pop.
    do_reset();
    drive(1, {2'b11, 4'd5, 4'd6, 22'h1}, NORTH, 1, 2'd1, 1); step();
    drive(1, {2'b11, 4'd7, 4'd2, 22'h2}, NORTH, 1, 2'd1, 1); step();
    drive(0, 32'h0, WEST, 1, 2'd3, 1); step();   // WAIT_VA, grant
    step();                                       // ACTIVE, pop first
    #1; chk("ht_fv", flit_valid_o, 1'b1); chk("ht_va_idle", va_request_o, 1'b0);
    step();                                       // IDLE, routes second
    #1; chk("ht_va_next", va_request_o, 1'b1); chk("ht_port", 64'(out_port_o), 64'(WEST));
    for (int i = 0; i < 4; i++) step();

    // Fill to full with no grants, then overflow.
    do_reset();
    drive(1, FH, SOUTH, 0, 2'd0, 0); step();
    for (int i = 0; i < 7; i++) begin drive(1, FB, SOUTH, 0, 2'd0, 0); step(); end
    drive(0, 32'h0, SOUTH, 0, 2'd0, 0);
    #1; chk("fill_full", full_o, 1'b1); chk("fill_err0", error_o, 1'b0);
    drive(1, FT, SOUTH, 0, 2'd0, 0); step();
    drive(0, 32'h0, SOUTH, 0, 2'd0, 0);
    #1; chk("ovf_err", error_o, 1'b1); chk("ovf_full", full_o, 1'b1);
    step();

    // Full with simultaneous push and pop: no drop.
    do_reset();
    drive(1, FH, SOUTH, 0, 2'd0, 0); step();
    for (int i = 0; i < 7; i++) begin drive(1, FB, SOUTH, (i == 1), 2'd1, 0); step(); end
    for (int i = 0; i < 3; i++) begin
      drive(1, FB, SOUTH, 0, 2'd0, 1); step();
      #1; chk("pp_full", full_o, 1'b1); chk("pp_err", error_o, 1'b0);
    end
    drive(0, 32'h0, SOUTH, 0, 2'd0, 0); step();

    // BODY at the head while idle.
    do_reset();
    drive(1, FB, EAST, 1, 2'd1, 1); step();
    drive(0, 32'h0, EAST, 1, 2'd1, 1);
    for (int i = 0; i < 3; i++) step();
    #1; chk("body_err", error_o, 1'b1); chk("body_va", va_request_o, 1'b0);
    chk("body_nopop", empty_o, 1'b0); chk("body_fv", flit_valid_o, 1'b0);

    // Asynchronous reset after two of three flits popped.
    do_reset();
    drive(1, FH, EAST, 1, 2'd2, 1); step();
    drive(1, FB, EAST, 1, 2'd2, 1); step();
    drive(1, FT, EAST, 1, 2'd2, 1); step();
    drive(0, 32'h0, EAST, 1, 2'd2, 1); step();    // pop H
    step();                                       // pop B
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", empty_o, 1'b1); chk("arst_fv", flit_valid_o, 1'b0);
    chk("arst_sa", sa_request_o, 1'b0); chk("arst_va", va_request_o, 1'b0);
    model_reset();
    drive(0, 32'h0, LOCAL, 0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Randomized well-formed packet stream against the model.
    do_reset();
    pkt_left = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 400 == 399) begin do_reset(); pkt_left = 0; end
      valid_i = ($urandom_range(0, 1) == 1) && ((mq.size() < DEPTH) || ($urandom_range(0, 7) == 0));
      if (valid_i) begin
        if (pkt_left == 0) begin
          int len = $urandom_range(1, 4);
          flit_i = mkflit(len == 1 ? 2'b11 : 2'b00);
          pkt_left = len - 1;
        end else begin
          pkt_left--;
          flit_i = mkflit(pkt_left > 0 ? 2'b01 : 2'b10);
        end
      end else flit_i = 32'($urandom);
      out_port_i = port_t'($urandom_range(0, 4));
      va_grant_i = ($urandom_range(0, 1) == 1);
      vc_id_i    = 2'($urandom);
      sa_grant_i = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
